keylock_ctrl: RTL and testbench
===============================

// Module: keylock_ctrl
// PURPOSE
//  Clocked sequencer for the keypad lock: accepts strobed 4-bit key digits, compares them against a
//  stored CODE_LEN-digit code, drives the locked output, and enforces lockout after repeated failures.
//  Adds auto-relock, inter-digit timeout and in-field code reprogramming while unlocked.
//  Sits between the keypad scanner (key/key_valid) and the actuator/status logic (locked, lockout).
// PARAMETERS
//  CODE_LEN        6          digits per code (2..8)
//  DEFAULT_CODE    24'h332556 code loaded at reset, first digit in MSB nibble; width CODE_LEN*4
//  MAX_FAIL        3          consecutive failed attempts that trigger lockout (1..15)
//  LOCKOUT_CYCLES  1000       cycles spent in LOCKOUT
//  RELOCK_CYCLES   5000       cycles in UNLOCKED before automatic relock
//  ENTRY_TIMEOUT   2000       max idle cycles between digits during ENTRY/PROG
// PORTS
//  clk        in   1   clock, all state on rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  key_valid  in   1   one-cycle strobe, key sampled when high
//  key        in   4   digit 0-9; 4'hF = CLEAR; 4'hA-4'hE = invalid digit
//  relock     in   1   level/pulse request to relock immediately
//  prog_en    in   1   when high in UNLOCKED, digits reprogram the code
//  locked     out  1   0 only in UNLOCKED/PROG
//  lockout    out  1   1 only in LOCKOUT
//  ok_pulse   out  1   1-cycle pulse on correct code (cycle entering UNLOCKED)
//  err_pulse  out  1   1-cycle pulse on failed attempt
//  fail_cnt   out  4   consecutive failed attempts
//  digit_cnt  out  3   digits accepted in current entry/prog sequence
// BEHAVIOUR
//  Reset values: locked=1, lockout=0, ok_pulse=0, err_pulse=0, fail_cnt=0, digit_cnt=0, state=IDLE,
//  code=DEFAULT_CODE, all timers 0.
//  States: IDLE, ENTRY, CHECK, UNLOCKED, PROG, LOCKOUT.
//  IDLE: key_valid with digit/invalid -> ENTRY, digit_cnt=1, mismatch flag = (key != code digit 0).
//    CLEAR ignored.
//  ENTRY: each key_valid increments digit_cnt, ORs mismatch for that position. Digits A-E always mismatch.
//    CLEAR -> IDLE, no failure counted. Timer reloads on every key; expiry -> IDLE, no failure.
//    On digit CODE_LEN -> CHECK (next cycle).
//  CHECK (1 cycle, key_valid ignored):
//    match -> UNLOCKED, ok_pulse, fail_cnt=0.
//    mismatch -> fail_cnt+1, err_pulse; if new fail_cnt==MAX_FAIL -> LOCKOUT else IDLE.
//    Latency: last digit strobe at cycle N -> locked=0 at N+2.
//  UNLOCKED: relock timer loads RELOCK_CYCLES on entry. Expiry or relock=1 -> IDLE (locked=1 next cycle).
//    key_valid with prog_en=1 and digit 0-9 -> PROG, digit captured to shadow slot 0, digit_cnt=1.
//    Other keys ignored.
//  PROG: digits 0-9 fill shadow register in order; the relock timer keeps running.
//    CLEAR, A-E, prog_en=0, or ENTRY_TIMEOUT -> back to UNLOCKED, shadow discarded.
//    On digit CODE_LEN, the shadow is committed to the code register in the same edge -> UNLOCKED.
//    digit_cnt=0 after commit.
//  LOCKOUT: all keys ignored; lockout=1, locked=1. Timer expiry -> IDLE, fail_cnt=0.
//  Priority, highest first: reset > relock > timer expiry > key_valid.
//  relock together with the final PROG digit -> IDLE, no commit. relock in IDLE/ENTRY/LOCKOUT has no effect.
//  fail_cnt saturates at MAX_FAIL. It is cleared only by a correct code, lockout expiry, or reset.
//  Reset asserted mid-operation (any state) -> immediate return to reset values, including code=DEFAULT_CODE.
//  ok_pulse and err_pulse are never high in the same cycle.
// STRUCTURE
//  Package keylock_pkg: state enum, KEY_CLEAR=4'hF, DIGIT_W=4, digit-valid function (key<=9).
//  Sub-module keylock_timer: loadable down-counter (load, value, expired); one instance each for
//    entry timeout, relock, and lockout.
//  Top level holds the FSM, code/shadow registers and counters.
// TESTING (CODE_LEN=6, MAX_FAIL=3, LOCKOUT_CYCLES=20, RELOCK_CYCLES=50, ENTRY_TIMEOUT=10)
//  Keys 3,3,2,5,5,6 -> ok_pulse at last+1, locked=0 at last+2, fail_cnt=0; relock after 50 cycles.
//  Keys 3,3,2,5,5,7 three times -> err_pulse x3, fail_cnt=3, lockout=1 for 20 cycles; keys ignored
//    meanwhile; then fail_cnt=0.
//  Keys 3,3, then idle 10 cycles -> IDLE, digit_cnt=0, fail_cnt unchanged. Same result for 3,3,F.
//  Unlocked, prog_en=1, keys 1,2,3,4,5,6 -> commit; relock; old code fails, 1,2,3,4,5,6 unlocks.
//  PROG with relock on final digit -> IDLE, code unchanged; reset mid-ENTRY -> all reset values.

Source files
------------

// File: rtl/keylock_pkg.sv
// Shared types and helpers for the keypad lock sequencer.
// Holds the FSM state set, key encodings and counter widths.
package keylock_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CNT_W   = 4;

  localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_UNLOCKED,
    ST_PROG,
    ST_LOCKOUT
  } state_t;

  // Only 0-9 are real digits; A-E are invalid and F is CLEAR.
  function automatic logic is_digit(input logic [DIGIT_W-1:0] k);
    return k <= DIGIT_W'(9);
  endfunction

endpackage

// File: rtl/keylock_timer.sv
// Loadable down-counter; o_expired_c is high on the cycle whose rising edge
// lands exactly i_value cycles after the load edge.
module keylock_timer
  import keylock_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expired_c
);

  logic [W-1:0] r_cnt;

  // A count of zero is idle, so an unloaded timer never expires.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired_c = (r_cnt == W'(1));

endmodule

// File: rtl/keylock_ctrl.sv
// Keypad lock sequencer: code entry and check, failure lockout, auto-relock,
// inter-digit timeout and in-field code reprogramming while unlocked.
module keylock_ctrl
  import keylock_pkg::*;
#(
  parameter int unsigned                      CODE_LEN       = 6,
  parameter logic [CODE_LEN*DIGIT_W-1:0]      DEFAULT_CODE   = 24'h332556,
  parameter int unsigned                      MAX_FAIL       = 3,
  parameter int unsigned                      LOCKOUT_CYCLES = 1000,
  parameter int unsigned                      RELOCK_CYCLES  = 5000,
  parameter int unsigned                      ENTRY_TIMEOUT  = 2000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key,
  input  logic               relock,
  input  logic               prog_en,
  output logic               locked,
  output logic               lockout,
  output logic               ok_pulse,
  output logic               err_pulse,
  output logic [3:0]         fail_cnt,
  output logic [2:0]         digit_cnt
);

  localparam int unsigned IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned ENT_W = $clog2(ENTRY_TIMEOUT + 1);
  localparam int unsigned REL_W = $clog2(RELOCK_CYCLES + 1);
  localparam int unsigned LCK_W = $clog2(LOCKOUT_CYCLES + 1);

  // Element CODE_LEN-1 is the first digit (MSB nibble).
  typedef logic [CODE_LEN-1:0][DIGIT_W-1:0] code_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_digit_cnt, w_digit_cnt_nxt;
  logic [CNT_W-1:0] r_fail_cnt, w_fail_cnt_nxt;
  logic             r_mismatch, w_mismatch_nxt;
  logic             r_pass, w_pass_nxt;
  code_t            r_code, w_code_nxt;
  code_t            r_shadow, w_shadow_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_lockout, w_lockout_nxt;
  logic             r_ok, w_ok_nxt;
  logic             r_err, w_err_nxt;

  logic             w_entry_load, w_relock_load, w_lock_load;
  logic             w_entry_exp, w_relock_exp, w_lock_exp;
  logic [IDX_W-1:0] w_slot;
  logic             w_key_miss;
  logic             w_last;
  logic             w_fail_limit;
  logic [CNT_W-1:0] w_fail_inc;

  keylock_timer #(.W(ENT_W)) u_entry_tmr (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_load      (w_entry_load),
    .i_value     (ENT_W'(ENTRY_TIMEOUT)),
    .o_expired_c (w_entry_exp)
  );

  keylock_timer #(.W(REL_W)) u_relock_tmr (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_load      (w_relock_load),
    .i_value     (REL_W'(RELOCK_CYCLES)),
    .o_expired_c (w_relock_exp)
  );

  keylock_timer #(.W(LCK_W)) u_lock_tmr (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_load      (w_lock_load),
    .i_value     (LCK_W'(LOCKOUT_CYCLES)),
    .o_expired_c (w_lock_exp)
  );

  // Slot addressed by the digit about to be accepted (digit_cnt is 0 in IDLE).
  assign w_slot       = IDX_W'(CODE_LEN - 1) - IDX_W'(r_digit_cnt);
  assign w_key_miss   = !is_digit(key) || (key != r_code[w_slot]);
  assign w_last       = (r_digit_cnt == CNT_W'(CODE_LEN - 1));
  assign w_fail_limit = (r_fail_cnt >= CNT_W'(MAX_FAIL));
  assign w_fail_inc   = w_fail_limit ? r_fail_cnt : r_fail_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_digit_cnt_nxt = r_digit_cnt;
    w_fail_cnt_nxt  = r_fail_cnt;
    w_mismatch_nxt  = r_mismatch;
    w_pass_nxt      = r_pass;
    w_code_nxt      = r_code;
    w_shadow_nxt    = r_shadow;
    w_ok_nxt        = 1'b0;
    w_err_nxt       = 1'b0;
    w_entry_load    = 1'b0;
    w_relock_load   = 1'b0;
    w_lock_load     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (key_valid && (key != KEY_CLEAR)) begin
          w_state_nxt     = ST_ENTRY;
          w_digit_cnt_nxt = CNT_W'(1);
          w_mismatch_nxt  = w_key_miss;
          w_entry_load    = 1'b1;
        end
      end

      ST_ENTRY: begin
        if (w_entry_exp) begin
          w_state_nxt     = ST_IDLE;
          w_digit_cnt_nxt = '0;
        end else if (key_valid) begin
          if (key == KEY_CLEAR) begin
            w_state_nxt     = ST_IDLE;
            w_digit_cnt_nxt = '0;
          end else begin
            w_digit_cnt_nxt = r_digit_cnt + CNT_W'(1);
            w_mismatch_nxt  = r_mismatch | w_key_miss;
            if (w_last) begin
              // Verdict is known here, so the pulses show during the CHECK cycle.
              w_state_nxt = ST_CHECK;
              w_pass_nxt  = !(r_mismatch | w_key_miss);
              w_ok_nxt    = !(r_mismatch | w_key_miss);
              w_err_nxt   = r_mismatch | w_key_miss;
            end else begin
              w_entry_load = 1'b1;
            end
          end
        end
      end

      ST_CHECK: begin
        w_digit_cnt_nxt = '0;
        if (r_pass) begin
          w_state_nxt    = ST_UNLOCKED;
          w_fail_cnt_nxt = '0;
          w_relock_load  = 1'b1;
        end else begin
          w_fail_cnt_nxt = w_fail_inc;
          if (w_fail_inc >= CNT_W'(MAX_FAIL)) begin
            w_state_nxt = ST_LOCKOUT;
            w_lock_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_UNLOCKED: begin
        if (relock || w_relock_exp) begin
          w_state_nxt = ST_IDLE;
        end else if (key_valid && prog_en && is_digit(key)) begin
          w_state_nxt                = ST_PROG;
          w_shadow_nxt[CODE_LEN - 1] = key;
          w_digit_cnt_nxt            = CNT_W'(1);
          w_entry_load               = 1'b1;
        end
      end

      ST_PROG: begin
        if (relock || w_relock_exp) begin
          w_state_nxt     = ST_IDLE;
          w_digit_cnt_nxt = '0;
        end else if (w_entry_exp || !prog_en) begin
          w_state_nxt     = ST_UNLOCKED;
          w_digit_cnt_nxt = '0;
        end else if (key_valid) begin
          if (!is_digit(key)) begin
            w_state_nxt     = ST_UNLOCKED;
            w_digit_cnt_nxt = '0;
          end else begin
            w_shadow_nxt[w_slot] = key;
            if (w_last) begin
              w_code_nxt      = w_shadow_nxt;
              w_state_nxt     = ST_UNLOCKED;
              w_digit_cnt_nxt = '0;
            end else begin
              w_digit_cnt_nxt = r_digit_cnt + CNT_W'(1);
              w_entry_load    = 1'b1;
            end
          end
        end
      end

      ST_LOCKOUT: begin
        if (w_lock_exp) begin
          w_state_nxt    = ST_IDLE;
          w_fail_cnt_nxt = '0;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_digit_cnt_nxt = '0;
      end
    endcase

    w_locked_nxt  = !((w_state_nxt == ST_UNLOCKED) || (w_state_nxt == ST_PROG));
    w_lockout_nxt = (w_state_nxt == ST_LOCKOUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_digit_cnt <= '0;
      r_fail_cnt  <= '0;
      r_mismatch  <= 1'b0;
      r_pass      <= 1'b0;
      r_code      <= DEFAULT_CODE;
      r_shadow    <= '0;
      r_locked    <= 1'b1;
      r_lockout   <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_digit_cnt <= w_digit_cnt_nxt;
      r_fail_cnt  <= w_fail_cnt_nxt;
      r_mismatch  <= w_mismatch_nxt;
      r_pass      <= w_pass_nxt;
      r_code      <= w_code_nxt;
      r_shadow    <= w_shadow_nxt;
      r_locked    <= w_locked_nxt;
      r_lockout   <= w_lockout_nxt;
      r_ok        <= w_ok_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign locked    = r_locked;
  assign lockout   = r_lockout;
  assign ok_pulse  = r_ok;
  assign err_pulse = r_err;
  assign fail_cnt  = r_fail_cnt;
  assign digit_cnt = r_digit_cnt[2:0];

endmodule

// File: tb/tb_keylock_ctrl.sv
// Bench for keylock_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a deadline/queue model.
module tb_keylock_ctrl;

  localparam int unsigned CL = 6;
  localparam int unsigned MF = 3;
  localparam int unsigned LC = 20;
  localparam int unsigned RC = 50;
  localparam int unsigned ET = 10;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_UNLOCKED = 3, M_PROG = 4, M_LOCKOUT = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'h0;
  logic       relock = 1'b0;
  logic       prog_en = 1'b0;
  logic       locked, lockout, ok_pulse, err_pulse;
  logic [3:0] fail_cnt;
  logic [2:0] digit_cnt;

  always #5 clk = ~clk;

  keylock_ctrl #(
    .CODE_LEN       (CL),
    .DEFAULT_CODE   (24'h332556),
    .MAX_FAIL       (MF),
    .LOCKOUT_CYCLES (LC),
    .RELOCK_CYCLES  (RC),
    .ENTRY_TIMEOUT  (ET)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key       (key),
    .relock    (relock),
    .prog_en   (prog_en),
    .locked    (locked),
    .lockout   (lockout),
    .ok_pulse  (ok_pulse),
    .err_pulse (err_pulse),
    .fail_cnt  (fail_cnt),
    .digit_cnt (digit_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: operating mode, entered digits, absolute cycle deadlines for timers.
  int m_mode;
  int m_entered[$];
  int m_shadow[$];
  int m_code[CL];
  int m_fail;
  bit m_pass;
  bit e_ok, e_err;
  int cyc = 0;
  int edl, rdl, ldl;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    logic [23:0] dc;
    dc = 24'h332556;
    m_mode = M_IDLE;
    m_entered.delete();
    m_shadow.delete();
    for (int i = 0; i < CL; i++) m_code[i] = int'(dc[(CL-1-i)*4 +: 4]);
    m_fail = 0;
    m_pass = 0;
    e_ok = 0;
    e_err = 0;
  endtask

  task automatic model_step(input bit kv, input int k, input bit rl, input bit pe);
    cyc++;
    e_ok = 0;
    e_err = 0;
    case (m_mode)
      M_IDLE: begin
        if (kv && k != 15) begin
          m_entered.delete();
          m_entered.push_back(k);
          m_mode = M_ENTRY;
          edl = cyc + ET;
        end
      end
      M_ENTRY: begin
        if (cyc == edl) begin
          m_mode = M_IDLE; m_entered.delete();
        end else if (kv) begin
          if (k == 15) begin
            m_mode = M_IDLE; m_entered.delete();
          end else begin
            m_entered.push_back(k);
            if (m_entered.size() == CL) begin
              m_pass = 1;
              for (int i = 0; i < CL; i++) if (m_entered[i] != m_code[i]) m_pass = 0;
              e_ok = m_pass;
              e_err = !m_pass;
              m_mode = M_CHECK;
            end else begin
              edl = cyc + ET;
            end
          end
        end
      end
      M_CHECK: begin
        m_entered.delete();
        if (m_pass) begin
          m_mode = M_UNLOCKED; m_fail = 0; rdl = cyc + RC;
        end else begin
          m_fail = (m_fail + 1 > MF) ? MF : m_fail + 1;
          if (m_fail == MF) begin
            m_mode = M_LOCKOUT; ldl = cyc + LC;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
      M_UNLOCKED: begin
        if (rl || cyc == rdl) begin
          m_mode = M_IDLE;
        end else if (kv && pe && k <= 9) begin
          m_shadow.delete();
          m_shadow.push_back(k);
          m_mode = M_PROG;
          edl = cyc + ET;
        end
      end
      M_PROG: begin
        if (rl || cyc == rdl) begin
          m_mode = M_IDLE; m_shadow.delete();
        end else if (cyc == edl || !pe) begin
          m_mode = M_UNLOCKED; m_shadow.delete();
        end else if (kv) begin
          if (k > 9) begin
            m_mode = M_UNLOCKED; m_shadow.delete();
          end else begin
            m_shadow.push_back(k);
            if (m_shadow.size() == CL) begin
              for (int i = 0; i < CL; i++) m_code[i] = m_shadow[i];
              m_mode = M_UNLOCKED; m_shadow.delete();
            end else begin
              edl = cyc + ET;
            end
          end
        end
      end
      M_LOCKOUT: begin
        if (cyc == ldl) begin
          m_mode = M_IDLE; m_fail = 0;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic int exp_dcnt();
    if (m_mode == M_ENTRY) return m_entered.size();
    if (m_mode == M_PROG) return m_shadow.size();
    if (m_mode == M_CHECK) return CL;
    return 0;
  endfunction

  task automatic compare_all();
    chk("locked", int'(locked), (m_mode == M_UNLOCKED || m_mode == M_PROG) ? 0 : 1);
    chk("lockout", int'(lockout), (m_mode == M_LOCKOUT) ? 1 : 0);
    chk("ok_pulse", int'(ok_pulse), int'(e_ok));
    chk("err_pulse", int'(err_pulse), int'(e_err));
    chk("fail_cnt", int'(fail_cnt), m_fail);
    chk("digit_cnt", int'(digit_cnt), exp_dcnt());
  endtask

  task automatic cycle(input bit kv, input logic [3:0] k, input bit rl, input bit pe);
    key_valid = kv;
    key = k;
    relock = rl;
    prog_en = pe;
    @(posedge clk);
    model_step(kv, int'(k), rl, pe);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic enter6(input logic [23:0] c);
    for (int i = 0; i < CL; i++) cycle(1'b1, c[(CL-1-i)*4 +: 4], 1'b0, 1'b0);
  endtask

  // Reset is raised mid low-phase so its asynchronous effect is observed.
  task automatic do_reset();
    key_valid = 1'b0;
    relock = 1'b0;
    prog_en = 1'b0;
    reset = 1'b1;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare_all();
    reset = 1'b0;
  endtask

  function automatic logic [3:0] pick_key();
    int r;
    int pref;
    r = int'($urandom_range(0, 9));
    if (m_mode == M_ENTRY && m_entered.size() < CL) pref = m_code[m_entered.size()];
    else if (m_mode == M_PROG) pref = int'($urandom_range(0, 9));
    else pref = m_code[0];
    if (r < 6) return 4'(pref);
    if (r < 8) return 4'($urandom_range(0, 9));
    return 4'($urandom_range(10, 15));
  endfunction

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_locked", int'(locked), 1);
    chk("rst_lockout", int'(lockout), 0);
    chk("rst_fail_cnt", int'(fail_cnt), 0);
    chk("rst_digit_cnt", int'(digit_cnt), 0);

    // Correct default code, then auto-relock after RC cycles.
    enter6(24'h332556);
    chk("ok_at_last_plus1", int'(ok_pulse), 1);
    chk("locked_in_check", int'(locked), 1);
    idle(1);
    chk("unlocked_at_last_plus2", int'(locked), 0);
    chk("fail_after_ok", int'(fail_cnt), 0);
    idle(RC - 1);
    chk("still_unlocked", int'(locked), 0);
    idle(1);
    chk("auto_relock", int'(locked), 1);

    // Three wrong attempts lead to lockout; keys ignored while locked out.
    for (int a = 0; a < 3; a++) begin
      enter6(24'h332557);
      chk("err_pulse_wrong", int'(err_pulse), 1);
      idle(1);
    end
    chk("lockout_set", int'(lockout), 1);
    chk("fail_saturated", int'(fail_cnt), 3);
    for (int i = 0; i < LC - 1; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    chk("lockout_held", int'(lockout), 1);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    chk("lockout_released", int'(lockout), 0);
    chk("fail_cleared", int'(fail_cnt), 0);
    chk("key_dropped_at_expiry", int'(digit_cnt), 0);

    // Inter-digit timeout and CLEAR abandon entry without a failure.
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    idle(ET - 1);
    chk("entry_before_timeout", int'(digit_cnt), 2);
    idle(1);
    chk("entry_timed_out", int'(digit_cnt), 0);
    chk("timeout_no_fail", int'(fail_cnt), 0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 1'b0, 1'b0);
    chk("clear_abandons", int'(digit_cnt), 0);
    chk("clear_no_fail", int'(fail_cnt), 0);

    // Reprogram to 123456, relock, old code fails, new code unlocks.
    enter6(24'h332556);
    idle(1);
    for (int i = 0; i < CL; i++) cycle(1'b1, 4'(i + 1), 1'b0, 1'b1);
    chk("prog_commit_unlocked", int'(locked), 0);
    chk("prog_commit_dcnt", int'(digit_cnt), 0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    chk("relock_request", int'(locked), 1);
    enter6(24'h332556);
    chk("old_code_fails", int'(err_pulse), 1);
    idle(1);
    enter6(24'h123456);
    chk("new_code_ok", int'(ok_pulse), 1);
    idle(1);
    chk("new_code_unlocks", int'(locked), 0);

    // relock on the final PROG digit: no commit.
    for (int i = 0; i < CL - 1; i++) cycle(1'b1, 4'h9, 1'b0, 1'b1);
    cycle(1'b1, 4'h9, 1'b1, 1'b1);
    chk("relock_final_prog", int'(locked), 1);
    enter6(24'h999999);
    chk("no_commit_fails", int'(err_pulse), 1);
    idle(1);
    enter6(24'h123456);
    chk("code_kept", int'(ok_pulse), 1);
    idle(1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Reset mid-entry restores everything including the default code.
    enter6(24'h000000);
    idle(1);
    chk("one_failure", int'(fail_cnt), 1);
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    do_reset();
    chk("rst_mid_dcnt", int'(digit_cnt), 0);
    chk("rst_mid_fail", int'(fail_cnt), 0);
    enter6(24'h332556);
    chk("default_code_restored", int'(ok_pulse), 1);
    idle(1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 5000; n++) begin
      if ($urandom_range(0, 1999) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 1) == 1), pick_key(), ($urandom_range(0, 63) == 0),
              ($urandom_range(0, 3) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
